// File: rtl/dma_ddr_channel_guard.sv
// ============================================================================
// dma_ddr_channel_guard: latches the active DMA descriptor's DDR bank and
// gates AXI-MM AR/AW requests so the bank never changes with traffic in flight.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dma_ddr_channel_guard #(
  parameter int NUM_LOCAL_MEM_BANKS = 2,
  parameter int ADDR_WIDTH          = 34,
  parameter int MAX_OUTSTANDING     = 64,
  localparam int SEL_W = (NUM_LOCAL_MEM_BANKS > 1) ? $clog2(NUM_LOCAL_MEM_BANKS) : 1,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [1:0]            desc_mode,
  input  logic [ADDR_WIDTH-1:0] desc_src_addr,
  input  logic [ADDR_WIDTH-1:0] desc_dest_addr,
  input  logic                  xfer_done,
  output logic [1:0]            active_mode,
  output logic [SEL_W-1:0]      channel_sel,
  output logic                  active,
  input  logic                  eng_arvalid,
  output logic                  eng_arready,
  output logic                  ddr_arvalid,
  input  logic                  ddr_arready,
  input  logic                  eng_awvalid,
  output logic                  eng_awready,
  output logic                  ddr_awvalid,
  input  logic                  ddr_awready,
  input  logic                  ddr_rvalid,
  input  logic                  ddr_rready,
  input  logic                  ddr_rlast,
  input  logic                  ddr_bvalid,
  input  logic                  ddr_bready,
  output logic [CNT_W-1:0]      rd_outstanding,
  output logic [CNT_W-1:0]      wr_outstanding,
  output logic                  err_bad_bank,
  output logic                  err_underflow
);

  localparam logic [1:0] MODE_DDR_TO_HOST = 2'd1;
  localparam logic [1:0] MODE_HOST_TO_DDR = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] channel_sel_q, channel_sel_d;
  logic [1:0]       active_mode_q, active_mode_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             err_bad_bank_q, err_bad_bank_d;
  logic             err_underflow_q, err_underflow_d;

  logic             rd_ok, wr_ok;
  logic             ar_hs, aw_hs, r_hs, b_hs;
  logic [SEL_W-1:0] desc_sel;

  // Only the bank-select bits of the descriptor addresses matter here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{desc_src_addr[ADDR_WIDTH-SEL_W-1:0],
                              desc_dest_addr[ADDR_WIDTH-SEL_W-1:0]};

  assign rd_ok = (state_q == ST_ACTIVE) && (rd_cnt_q < CNT_W'(MAX_OUTSTANDING));
  assign wr_ok = (state_q == ST_ACTIVE) && (wr_cnt_q < CNT_W'(MAX_OUTSTANDING));

  assign ddr_arvalid = eng_arvalid && rd_ok;
  assign eng_arready = ddr_arready && rd_ok;
  assign ddr_awvalid = eng_awvalid && wr_ok;
  assign eng_awready = ddr_awready && wr_ok;

  assign ar_hs = eng_arvalid && ddr_arready && rd_ok;
  assign aw_hs = eng_awvalid && ddr_awready && wr_ok;
  assign r_hs  = ddr_rvalid && ddr_rready && ddr_rlast;
  assign b_hs  = ddr_bvalid && ddr_bready;

  always_comb begin
    state_d         = state_q;
    channel_sel_d   = channel_sel_q;
    active_mode_d   = active_mode_q;
    rd_cnt_d        = rd_cnt_q;
    wr_cnt_d        = wr_cnt_q;
    err_bad_bank_d  = err_bad_bank_q;
    err_underflow_d = err_underflow_q;
    desc_sel        = '0;

    if (desc_mode == MODE_DDR_TO_HOST) begin
      desc_sel = desc_src_addr[ADDR_WIDTH-1 -: SEL_W];
    end else if (desc_mode == MODE_HOST_TO_DDR) begin
      desc_sel = desc_dest_addr[ADDR_WIDTH-1 -: SEL_W];
    end

    // A simultaneous increment and decrement cancel, including at zero.
    if (ar_hs && !r_hs) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end else if (r_hs && !ar_hs) begin
      if (rd_cnt_q == '0) err_underflow_d = 1'b1;
      else                rd_cnt_d = rd_cnt_q - CNT_W'(1);
    end

    if (aw_hs && !b_hs) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end else if (b_hs && !aw_hs) begin
      if (wr_cnt_q == '0) err_underflow_d = 1'b1;
      else                wr_cnt_d = wr_cnt_q - CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (desc_valid) begin
          if ({1'b0, desc_sel} >= (SEL_W + 1)'(NUM_LOCAL_MEM_BANKS)) begin
            err_bad_bank_d = 1'b1;
          end else begin
            channel_sel_d = desc_sel;
            active_mode_d = desc_mode;
            state_d       = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        if (xfer_done) begin
          if (rd_cnt_q == '0 && wr_cnt_q == '0 && !ar_hs && !aw_hs) state_d = ST_IDLE;
          else                                                      state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Release as soon as the last response lands so the next descriptor waits no longer.
        if (rd_cnt_d == '0 && wr_cnt_d == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      channel_sel_q   <= '0;
      active_mode_q   <= '0;
      rd_cnt_q        <= '0;
      wr_cnt_q        <= '0;
      err_bad_bank_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      channel_sel_q   <= channel_sel_d;
      active_mode_q   <= active_mode_d;
      rd_cnt_q        <= rd_cnt_d;
      wr_cnt_q        <= wr_cnt_d;
      err_bad_bank_q  <= err_bad_bank_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign desc_ready     = (state_q == ST_IDLE);
  assign active         = (state_q != ST_IDLE);
  assign channel_sel    = channel_sel_q;
  assign active_mode    = active_mode_q;
  assign rd_outstanding = rd_cnt_q;
  assign wr_outstanding = wr_cnt_q;
  assign err_bad_bank   = err_bad_bank_q;
  assign err_underflow  = err_underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_ddr_channel_guard.sv
// ============================================================================
// tb_dma_ddr_channel_guard: directed + random stimulus against a cycle-level
// reference model; expected outputs are queued and checked by a monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dma_ddr_channel_guard;

  localparam int NB    = 3;
  localparam int AW    = 34;
  localparam int MAXO  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 3;

  localparam logic [1:0] D2H = 2'd1;
  localparam logic [1:0] H2D = 2'd2;

  localparam int S_IDLE = 0;
  localparam int S_ACT  = 1;
  localparam int S_DRN  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             desc_valid;
  logic             desc_ready;
  logic [1:0]       desc_mode;
  logic [AW-1:0]    desc_src_addr;
  logic [AW-1:0]    desc_dest_addr;
  logic             xfer_done;
  logic [1:0]       active_mode;
  logic [SEL_W-1:0] channel_sel;
  logic             active;
  logic             eng_arvalid, eng_arready, ddr_arvalid, ddr_arready;
  logic             eng_awvalid, eng_awready, ddr_awvalid, ddr_awready;
  logic             ddr_rvalid, ddr_rready, ddr_rlast;
  logic             ddr_bvalid, ddr_bready;
  logic [CNT_W-1:0] rd_outstanding, wr_outstanding;
  logic             err_bad_bank, err_underflow;

  dma_ddr_channel_guard #(
    .NUM_LOCAL_MEM_BANKS(NB),
    .ADDR_WIDTH(AW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_mode(desc_mode),
    .desc_src_addr(desc_src_addr), .desc_dest_addr(desc_dest_addr),
    .xfer_done(xfer_done), .active_mode(active_mode), .channel_sel(channel_sel),
    .active(active),
    .eng_arvalid(eng_arvalid), .eng_arready(eng_arready),
    .ddr_arvalid(ddr_arvalid), .ddr_arready(ddr_arready),
    .eng_awvalid(eng_awvalid), .eng_awready(eng_awready),
    .ddr_awvalid(ddr_awvalid), .ddr_awready(ddr_awready),
    .ddr_rvalid(ddr_rvalid), .ddr_rready(ddr_rready), .ddr_rlast(ddr_rlast),
    .ddr_bvalid(ddr_bvalid), .ddr_bready(ddr_bready),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .err_bad_bank(err_bad_bank), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int desc_ready, active, mode, sel;
    int arv, arr, awv, awr;
    int rd, wr, ebb, euf;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: transfer bookkeeping as plain integers.
  int m_st = S_IDLE, m_rd = 0, m_wr = 0, m_sel = 0, m_mode = 0, m_ebb = 0, m_euf = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int bank_of(logic [AW-1:0] a);
    return int'(a >> 32);
  endfunction

  task automatic step();
    exp_t e;
    bit rd_ok, wr_ok, ar_acc, aw_acc, r_ret, b_ret;
    int n_st, n_rd, n_wr, n_sel, n_mode, n_ebb, n_euf, bank;
    rd_ok = (m_st == S_ACT) && (m_rd < MAXO);
    wr_ok = (m_st == S_ACT) && (m_wr < MAXO);
    e.desc_ready = (m_st == S_IDLE);
    e.active     = (m_st != S_IDLE);
    e.mode = m_mode;  e.sel = m_sel;
    e.arv = int'(eng_arvalid && rd_ok);  e.arr = int'(ddr_arready && rd_ok);
    e.awv = int'(eng_awvalid && wr_ok);  e.awr = int'(ddr_awready && wr_ok);
    e.rd = m_rd;  e.wr = m_wr;  e.ebb = m_ebb;  e.euf = m_euf;
    sb_q.push_back(e);

    ar_acc = eng_arvalid && ddr_arready && rd_ok;
    aw_acc = eng_awvalid && ddr_awready && wr_ok;
    r_ret  = ddr_rvalid && ddr_rready && ddr_rlast;
    b_ret  = ddr_bvalid && ddr_bready;
    n_st = m_st; n_sel = m_sel; n_mode = m_mode; n_ebb = m_ebb; n_euf = m_euf;
    n_rd = m_rd + int'(ar_acc) - int'(r_ret);
    n_wr = m_wr + int'(aw_acc) - int'(b_ret);
    if (n_rd < 0) begin n_rd = 0; n_euf = 1; end
    if (n_wr < 0) begin n_wr = 0; n_euf = 1; end
    if (m_st == S_IDLE && desc_valid) begin
      bank = (desc_mode == D2H) ? bank_of(desc_src_addr) :
             (desc_mode == H2D) ? bank_of(desc_dest_addr) : 0;
      if (bank >= NB) n_ebb = 1;
      else begin n_sel = bank; n_mode = int'(desc_mode); n_st = S_ACT; end
    end else if (m_st == S_ACT && xfer_done) begin
      n_st = (m_rd == 0 && m_wr == 0 && !ar_acc && !aw_acc) ? S_IDLE : S_DRN;
    end else if (m_st == S_DRN && n_rd == 0 && n_wr == 0) begin
      n_st = S_IDLE;
    end
    if (reset) begin
      n_st = S_IDLE; n_rd = 0; n_wr = 0; n_sel = 0; n_mode = 0; n_ebb = 0; n_euf = 0;
    end

    @(posedge clk);
    m_st = n_st; m_rd = n_rd; m_wr = n_wr; m_sel = n_sel; m_mode = n_mode;
    m_ebb = n_ebb; m_euf = n_euf;
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle_inputs();
    reset = 0; desc_valid = 0; desc_mode = 0; desc_src_addr = '0; desc_dest_addr = '0;
    xfer_done = 0; eng_arvalid = 0; ddr_arready = 0; eng_awvalid = 0; ddr_awready = 0;
    ddr_rvalid = 0; ddr_rready = 0; ddr_rlast = 0; ddr_bvalid = 0; ddr_bready = 0;
  endtask

  task automatic send_desc(input logic [1:0] mode, input logic [AW-1:0] src, input logic [AW-1:0] dst);
    desc_valid = 1; desc_mode = mode; desc_src_addr = src; desc_dest_addr = dst;
    step();
    desc_valid = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("desc_ready",     int'(desc_ready),     e.desc_ready);
        chk("active",         int'(active),         e.active);
        chk("active_mode",    int'(active_mode),    e.mode);
        chk("channel_sel",    int'(channel_sel),    e.sel);
        chk("ddr_arvalid",    int'(ddr_arvalid),    e.arv);
        chk("eng_arready",    int'(eng_arready),    e.arr);
        chk("ddr_awvalid",    int'(ddr_awvalid),    e.awv);
        chk("eng_awready",    int'(eng_awready),    e.awr);
        chk("rd_outstanding", int'(rd_outstanding), e.rd);
        chk("wr_outstanding", int'(wr_outstanding), e.wr);
        chk("err_bad_bank",   int'(err_bad_bank),   e.ebb);
        chk("err_underflow",  int'(err_underflow),  e.euf);
      end
    end
  end

  initial begin : stimulus
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    step();
    reset = 0;
    steps(2);

    // Bank decode from the destination address.
    send_desc(H2D, '0, 34'h1_0000_0040);
    chk("decode_sel", int'(channel_sel), 1);
    chk("decode_active", int'(active), 1);
    chk("decode_ready", int'(desc_ready), 0);

    // Three reads, then drain before the bank may switch.
    eng_arvalid = 1; ddr_arready = 1;
    steps(3);
    eng_arvalid = 0;
    chk("three_reads", int'(rd_outstanding), 3);
    xfer_done = 1; step(); xfer_done = 0;
    steps(4);
    ddr_rvalid = 1; ddr_rready = 1; ddr_rlast = 1;
    steps(3);
    ddr_rvalid = 0; ddr_rlast = 0;
    chk("drained_rd", int'(rd_outstanding), 0);
    chk("drained_ready", int'(desc_ready), 1);
    send_desc(D2H, 34'h0_1234_5678, 34'h3_0000_0000);
    chk("switch_sel", int'(channel_sel), 0);
    chk("switch_mode", int'(active_mode), int'(D2H));

    // Write limit throttling.
    eng_awvalid = 1; ddr_awready = 1;
    steps(6);
    chk("limit_wr", int'(wr_outstanding), MAXO);
    chk("limit_awvalid", int'(ddr_awvalid), 0);
    chk("limit_awready", int'(eng_awready), 0);
    ddr_bvalid = 1; ddr_bready = 1; step(); ddr_bvalid = 0;
    steps(3);
    chk("one_more_aw", int'(wr_outstanding), MAXO);

    // Simultaneous increment and decrement.
    eng_awvalid = 0; ddr_bvalid = 1;
    steps(2);
    eng_awvalid = 1;
    step();
    eng_awvalid = 0; ddr_bvalid = 0;
    chk("aw_b_same", int'(wr_outstanding), 2);
    eng_arvalid = 1;
    steps(2);
    ddr_rvalid = 1; ddr_rlast = 1;
    step();
    eng_arvalid = 0;
    chk("ar_r_same", int'(rd_outstanding), 2);
    ddr_bvalid = 1;
    steps(2);
    idle_inputs();
    xfer_done = 1; step(); xfer_done = 0;
    chk("direct_idle", int'(desc_ready), 1);

    // Error flags.
    send_desc(H2D, '0, 34'h3_0000_0000);
    chk("bad_bank_flag", int'(err_bad_bank), 1);
    chk("bad_bank_idle", int'(desc_ready), 1);
    chk("bad_bank_sel", int'(channel_sel), 0);
    ddr_bvalid = 1; ddr_bready = 1; step(); ddr_bvalid = 0;
    chk("underflow_flag", int'(err_underflow), 1);
    chk("underflow_wr", int'(wr_outstanding), 0);

    // Reset while draining.
    send_desc(D2H, 34'h2_0000_0000, '0);
    chk("bank2_sel", int'(channel_sel), 2);
    eng_arvalid = 1; ddr_arready = 1;
    steps(4);
    eng_arvalid = 0;
    xfer_done = 1; step(); xfer_done = 0;
    chk("drain_rd", int'(rd_outstanding), MAXO);
    chk("drain_active", int'(active), 1);
    reset = 1; step(); reset = 0;
    chk("rst_rd", int'(rd_outstanding), 0);
    chk("rst_ready", int'(desc_ready), 1);
    chk("rst_ebb", int'(err_bad_bank), 0);
    chk("rst_euf", int'(err_underflow), 0);
    chk("rst_sel", int'(channel_sel), 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(0, 299) == 0);
      desc_valid     = ($urandom_range(0, 3) == 0);
      desc_mode      = 2'($urandom_range(0, 3));
      desc_src_addr  = {2'($urandom_range(0, 3)), 32'($urandom)};
      desc_dest_addr = {2'($urandom_range(0, 3)), 32'($urandom)};
      xfer_done      = ($urandom_range(0, 15) == 0);
      eng_arvalid    = 1'($urandom_range(0, 1));
      ddr_arready    = 1'($urandom_range(0, 1));
      eng_awvalid    = 1'($urandom_range(0, 1));
      ddr_awready    = 1'($urandom_range(0, 1));
      ddr_rvalid     = (m_rd > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
      ddr_rready     = ($urandom_range(0, 3) != 0);
      ddr_rlast      = 1'($urandom_range(0, 1));
      ddr_bvalid     = (m_wr > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
      ddr_bready     = ($urandom_range(0, 3) != 0);
      step();
    end

    idle_inputs();
    steps(2);
    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dma_ddr_channel_guard.md
Name: dma_ddr_channel_guard

Overview:
- Sits between the DMA descriptor/transfer engine and the DDR channel selector.
- Latches the active descriptor and derives a stable DDR bank select from it.
- Tracks outstanding AXI-MM reads and writes on the selected DDR path and throttles new requests at the outstanding limit.
- Accepts a new descriptor (and so changes bank) only after all traffic for the previous one has drained, so the selector never switches bank with transactions in flight.

Parameters:
- NUM_LOCAL_MEM_BANKS, 2, number of DDR banks behind the selector.
- ADDR_WIDTH, 34, DDR byte-address width; bank select is addr[ADDR_WIDTH-1 -: SEL_W], where SEL_W = max(1, $clog2(NUM_LOCAL_MEM_BANKS)).
- MAX_OUTSTANDING, 64, per-direction limit on outstanding transactions; must be ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- desc_valid  in  1  new descriptor offered.
- desc_ready  out  1  descriptor accepted when desc_valid && desc_ready.
- desc_mode  in  2  dma_pkg mode (DDR_TO_HOST, HOST_TO_DDR, other).
- desc_src_addr  in  ADDR_WIDTH  source address.
- desc_dest_addr  in  ADDR_WIDTH  destination address.
- xfer_done  in  1  engine pulse: last request of the active descriptor issued.
- active_mode  out  2  latched mode.
- channel_sel  out  SEL_W  latched bank select, fed to the selector.
- active  out  1  guard is in ACTIVE or DRAIN.
- eng_arvalid / eng_arready  in / out  1  engine AR handshake.
- ddr_arvalid / ddr_arready  out / in  1  selector AR handshake.
- eng_awvalid / eng_awready  in / out  1  engine AW handshake.
- ddr_awvalid / ddr_awready  out / in  1  selector AW handshake.
- ddr_rvalid, ddr_rready, ddr_rlast  in  1 each  observed R beat (monitor only).
- ddr_bvalid, ddr_bready  in  1 each  observed B response (monitor only).
- rd_outstanding  out  $clog2(MAX_OUTSTANDING+1)  read count.
- wr_outstanding  out  $clog2(MAX_OUTSTANDING+1)  write count.
- err_bad_bank  out  1  sticky error.
- err_underflow  out  1  sticky error.

Behaviour:
- Reset values: state=IDLE; desc_ready=1 (combinational from IDLE); counts=0; channel_sel=0; active_mode=0; active=0; errors=0; ddr_arvalid=ddr_awvalid=0.
- States:
  - IDLE: desc_ready=1.
    - On accept, compute sel from desc_src_addr for DDR_TO_HOST, from desc_dest_addr for HOST_TO_DDR; any other mode gives sel=0.
    - If sel ≥ NUM_LOCAL_MEM_BANKS: set err_bad_bank, stay IDLE, leave latched outputs unchanged.
    - Else register sel and mode; go to ACTIVE on the next cycle.
  - ACTIVE: desc_ready=0. xfer_done → DRAIN; if both counts are already 0 that cycle with no accepts, go directly to IDLE.
  - DRAIN: desc_ready=0. Go to IDLE in the cycle after both counts reach 0.
  - channel_sel is stable throughout ACTIVE and DRAIN.
- Request gating (combinational, zero latency):
  - ddr_arvalid = eng_arvalid && state==ACTIVE && rd_outstanding<MAX_OUTSTANDING; eng_arready = ddr_arready under the same qualifier.
  - AW path is identical using wr_outstanding.
  - Requests are blocked in IDLE and DRAIN.
- Counters (registered):
  - Read: +1 on AR handshake, −1 on R handshake with rlast; both in the same cycle leaves it unchanged.
  - Write: +1 on AW handshake, −1 on B handshake; both in the same cycle leaves it unchanged.
  - Decrement at 0 without a simultaneous increment: count holds 0 and err_underflow is set.
  - A count never exceeds MAX_OUTSTANDING (enforced by gating).
- Error flags are sticky until reset.
- Reset mid-operation: all state, counts and errors clear next cycle regardless of in-flight traffic.
- A xfer_done in IDLE or DRAIN is ignored.

Test Plan:
- Bank decode: reset; HOST_TO_DDR, dest_addr=0x2_0000_0040 (ADDR_WIDTH=34, bit33=1) → channel_sel=1, active=1 one cycle after accept, desc_ready=0.
- Drain before switch: ACTIVE on bank 1, issue 3 AR accepts, pulse xfer_done, then send rlast R beats at cycles +5, +6, +7. Required: rd_outstanding 3→0; desc_ready=1 the cycle after the third beat; a DDR_TO_HOST descriptor with src bit33=0 then gives channel_sel=0.
- Limit throttle: MAX_OUTSTANDING=4, ddr_awready=1, eng_awvalid held high with no B → exactly 4 AW accepts, then ddr_awvalid=0 and eng_awready=0; one B → exactly one more AW accepted.
- Simultaneous events: AR accept and rlast beat in the same cycle at count=2 → count stays 2; same for AW+B.
- Errors: NUM_LOCAL_MEM_BANKS=1 and a descriptor whose select bit is 1 → err_bad_bank=1, state IDLE, channel_sel unchanged. B with wr_outstanding=0 → err_underflow=1, count stays 0.
- Reset mid-drain: DRAIN with rd_outstanding=5, assert reset for 1 cycle → next cycle counts=0, IDLE, errors cleared, desc_ready=1.
